seven_seg_capture: RTL and testbench

- Receive-side counterpart of the hex-to-seven-segment encoder. It samples a multiplexed, active-low seven-segment display bus (segment lines plus digit-select lines) and decodes each digit's pattern back to a 4-bit hex value.
- It qualifies each pattern for stability, flags illegal patterns, and holds one decoded value per digit.
- Used for display loop-back checking and for reading displays driven by another board.

---
 rtl/seven_seg_capture_if.sv | 24 ++
 rtl/seven_seg_capture.sv | 192 +++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_capture_if.sv
// Bundle of display-bus pins and decoded results for the seven-segment capture block.
// The master side drives the multiplexed display pins and observes the decoded view;
// the slave side is the capture block itself.
interface seven_seg_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [7:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   valid;
  logic [NUM_DIGITS-1:0]   err;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    update;

  modport master (
    output seg_n, an_n,
    input  digits, valid, err, dp, update
  );

  modport slave (
    input  seg_n, an_n,
    output digits, valid, err, dp, update
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Seven-segment display capture: synchronizes a multiplexed active-low display bus,
// waits for each digit pattern to be stable, then decodes it back to a hex value.
// Illegal patterns raise a per-digit error flag; a blank pattern clears valid only.
module seven_seg_capture #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  seven_seg_capture_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    HOLD
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        next_cnt;
  logic                    commit;

  logic [7:0]              seg_s1;
  logic [7:0]              seg_s2;
  logic [7:0]              seg_prev;
  logic [NUM_DIGITS-1:0]   an_s1;
  logic [NUM_DIGITS-1:0]   an_s2;
  logic [NUM_DIGITS-1:0]   an_prev;

  logic [NUM_DIGITS-1:0]   sel;
  logic                    qualifies;
  logic                    same;

  logic [3:0]              dec_val;
  logic                    dec_legal;
  logic                    dec_blank;

  logic [4*NUM_DIGITS-1:0] digits_r;
  logic [NUM_DIGITS-1:0]   valid_r;
  logic [NUM_DIGITS-1:0]   err_r;
  logic [NUM_DIGITS-1:0]   dp_r;
  logic                    update_r;

  // Two-flop synchronizer on the asynchronous pins plus a copy of the previous sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1   <= '0;
      seg_s2   <= '0;
      seg_prev <= '0;
      an_s1    <= '0;
      an_s2    <= '0;
      an_prev  <= '0;
    end else begin
      seg_s1   <= bus.seg_n;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      an_s1    <= bus.an_n;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
    end
  end

  // A sample qualifies only with exactly one digit select active
  always_comb begin
    sel       = ~an_s2;
    qualifies = ($countones(sel) == 1);
    same      = (seg_s2 == seg_prev) && (an_s2 == an_prev);
  end

  // Pattern decoder; only the segment field matters, the dp bit is handled separately
  always_comb begin
    dec_val   = 4'h0;
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    case (seg_s2[6:0])
      7'h40:   dec_val = 4'h0;
      7'h79:   dec_val = 4'h1;
      7'h24:   dec_val = 4'h2;
      7'h30:   dec_val = 4'h3;
      7'h19:   dec_val = 4'h4;
      7'h12:   dec_val = 4'h5;
      7'h02:   dec_val = 4'h6;
      7'h78:   dec_val = 4'h7;
      7'h00:   dec_val = 4'h8;
      7'h10:   dec_val = 4'h9;
      7'h08:   dec_val = 4'hA;
      7'h03:   dec_val = 4'hB;
      7'h46:   dec_val = 4'hC;
      7'h21:   dec_val = 4'hD;
      7'h06:   dec_val = 4'hE;
      7'h0E:   dec_val = 4'hF;
      7'h7F: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // State and run-length register for the stability qualifier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Run tracking: cnt counts consecutive identical qualifying samples; the commit fires
  // on the edge after the run has reached its full length, and HOLD blocks a re-commit
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (qualifies) begin
          next_state = QUAL;
          next_cnt   = CNT_W'(1);
        end
      end
      QUAL: begin
        if (!qualifies) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (!same) begin
          next_cnt   = CNT_W'(1);
        end else if (cnt == CNT_W'(STABLE_CNT)) begin
          next_state = HOLD;
          commit     = 1'b1;
        end else begin
          next_cnt   = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!qualifies) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (!same) begin
          next_state = QUAL;
          next_cnt   = CNT_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Commit the decoded pattern into the selected digit only; other digits keep their state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_r <= '0;
      valid_r  <= '0;
      err_r    <= '0;
      dp_r     <= '0;
      update_r <= 1'b0;
    end else begin
      update_r <= commit;
      if (commit) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            dp_r[i] <= ~seg_s2[7];
            if (dec_legal) begin
              digits_r[4*i +: 4] <= dec_val;
              valid_r[i]         <= 1'b1;
              err_r[i]           <= 1'b0;
            end else begin
              valid_r[i]         <= 1'b0;
              err_r[i]           <= ~dec_blank;
            end
          end
        end
      end
    end
  end

  assign bus.digits = digits_r;
  assign bus.valid  = valid_r;
  assign bus.err    = err_r;
  assign bus.dp     = dp_r;
  assign bus.update = update_r;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture: drives display dwells, predicts commits from a
// dwell-level model and checks every update pulse through a scoreboard queue.
module tb_seven_seg_capture;

  localparam int ND = 4;
  localparam int S  = 4;

  typedef struct {
    logic [4*ND-1:0] digits;
    logic [ND-1:0]   valid;
    logic [ND-1:0]   err;
    logic [ND-1:0]   dp;
  } snap_t;

  logic clk;
  logic rst;

  int checks;
  int failures;
  int upd_count;

  snap_t exp_q[$];

  logic [4*ND-1:0] m_digits;
  logic [ND-1:0]   m_valid;
  logic [ND-1:0]   m_err;
  logic [ND-1:0]   m_dp;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [7:0]    last_seg;
  logic [ND-1:0] last_an;

  seven_seg_capture_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_capture #(
    .NUM_DIGITS(ND),
    .STABLE_CNT(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench always ends
  initial begin
    #300000;
    $display("[TB] FAIL timeout reached before end of test");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_digits"}, 64'(bus.digits), 64'(m_digits));
    checkOutput({tag, "_valid"},  64'(bus.valid),  64'(m_valid));
    checkOutput({tag, "_err"},    64'(bus.err),    64'(m_err));
    checkOutput({tag, "_dp"},     64'(bus.dp),     64'(m_dp));
  endtask

  function automatic int find_digit(input logic [ND-1:0] an);
    int idx;
    int n;
    idx = -1;
    n   = 0;
    for (int i = 0; i < ND; i++) begin
      if (an[i] == 1'b0) begin
        idx = i;
        n++;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

  // Reference: what the display should show after digit idx has been shown seg long enough
  function automatic void model_commit(input logic [7:0] seg, input int idx);
    snap_t s;
    int    val;
    val = -1;
    for (int v = 0; v < 16; v++) begin
      if (seg_tab[v] == seg[6:0]) val = v;
    end
    if (val >= 0) begin
      m_digits[4*idx +: 4] = 4'(val);
      m_valid[idx]         = 1'b1;
      m_err[idx]           = 1'b0;
    end else if (seg[6:0] == 7'h7F) begin
      m_valid[idx] = 1'b0;
      m_err[idx]   = 1'b0;
    end else begin
      m_valid[idx] = 1'b0;
      m_err[idx]   = 1'b1;
    end
    m_dp[idx] = ~seg[7];
    s.digits  = m_digits;
    s.valid   = m_valid;
    s.err     = m_err;
    s.dp      = m_dp;
    exp_q.push_back(s);
  endfunction

  // One dwell: hold pins for len clocks; a qualifying dwell longer than S clocks commits once
  task automatic applyStimulus(input logic [7:0] seg, input logic [ND-1:0] an, input int len);
    int idx;
    idx = find_digit(an);
    if (idx >= 0 && len > S) model_commit(seg, idx);
    bus.seg_n = seg;
    bus.an_n  = an;
    last_seg  = seg;
    last_an   = an;
    repeat (len) @(negedge clk);
  endtask

  // Scoreboard monitor: every update pulse must match the next predicted display state
  always @(negedge clk) begin
    snap_t s;
    if (!rst && bus.update === 1'b1) begin
      upd_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_update actual=1 expected=0 at %0t", $time);
      end else begin
        s = exp_q.pop_front();
        checkOutput("commit_digits", 64'(bus.digits), 64'(s.digits));
        checkOutput("commit_valid",  64'(bus.valid),  64'(s.valid));
        checkOutput("commit_err",    64'(bus.err),    64'(s.err));
        checkOutput("commit_dp",     64'(bus.dp),     64'(s.dp));
      end
    end
  end

  initial begin
    logic [7:0]    seg;
    logic [ND-1:0] an;
    logic [7:0]    scan_seg [4];
    int            len;
    int            upd_before;
    bit            dpb;

    checks    = 0;
    failures  = 0;
    upd_count = 0;
    m_digits  = '0;
    m_valid   = '0;
    m_err     = '0;
    m_dp      = '0;
    scan_seg  = '{8'hB0, 8'h99, 8'h8E, 8'hC0};

    rst       = 1'b1;
    bus.seg_n = 8'hFF;
    bus.an_n  = '1;
    last_seg  = 8'hFF;
    last_an   = '1;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkState("reset");
    checkOutput("reset_update", 64'(bus.update), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] scan test");
    upd_before = upd_count;
    for (int pass = 0; pass < 2; pass++) begin
      for (int d = 0; d < ND; d++) begin
        an    = '1;
        an[d] = 1'b0;
        applyStimulus(scan_seg[d], an, 16);
      end
    end
    applyStimulus(8'hFF, '1, 10);
    checkOutput("scan_digits", 64'(bus.digits), 64'h0F43);
    checkOutput("scan_valid",  64'(bus.valid),  64'hF);
    checkOutput("scan_err",    64'(bus.err),    64'h0);
    checkOutput("scan_updates", 64'(upd_count - upd_before), 64'd8);
    checkState("scan");

    $display("[TB] glitch test");
    upd_before = upd_count;
    applyStimulus(8'hA4, 4'b1011, 10);
    applyStimulus(8'h80, 4'b1011, 3);
    applyStimulus(8'hA4, 4'b1011, 10);
    applyStimulus(8'hFF, '1, 10);
    checkOutput("glitch_digit2", 64'(bus.digits[11:8]), 64'h2);
    checkOutput("glitch_updates", 64'(upd_count - upd_before), 64'd2);
    checkState("glitch");

    $display("[TB] illegal and blank test");
    applyStimulus(8'hFE, 4'b1101, 10);
    applyStimulus(8'hFF, '1, 6);
    checkOutput("illegal_err1",    64'(bus.err[1]),      64'd1);
    checkOutput("illegal_valid1",  64'(bus.valid[1]),    64'd0);
    checkOutput("illegal_digit1",  64'(bus.digits[7:4]), 64'h4);
    applyStimulus(8'hFF, 4'b1101, 10);
    applyStimulus(8'hFF, '1, 6);
    checkOutput("blank_err1",   64'(bus.err[1]),   64'd0);
    checkOutput("blank_valid1", 64'(bus.valid[1]), 64'd0);

    $display("[TB] decimal point test");
    applyStimulus(8'h40, 4'b0111, 10);
    applyStimulus(8'hFF, '1, 6);
    checkOutput("dp_lit3",  64'(bus.dp[3]),          64'd1);
    checkOutput("dp_digit3", 64'(bus.digits[15:12]), 64'h0);
    checkState("dp");

    $display("[TB] bad select test");
    upd_before = upd_count;
    applyStimulus(8'h99, 4'b0000, 20);
    applyStimulus(8'h99, 4'b1111, 20);
    checkOutput("badsel_updates", 64'(upd_count - upd_before), 64'd0);
    checkState("badsel");

    $display("[TB] mid-qualification reset test");
    applyStimulus(8'hFF, '1, 10);
    bus.seg_n = 8'hF9;
    bus.an_n  = 4'b1110;
    last_seg  = 8'hF9;
    last_an   = 4'b1110;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    m_digits = '0;
    m_valid  = '0;
    m_err    = '0;
    m_dp     = '0;
    checkState("midreset");
    checkOutput("midreset_update", 64'(bus.update), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_commit(8'hF9, 0);
    repeat (S + 2) @(posedge clk);
    #1;
    checkOutput("latency_early_update", 64'(bus.update), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("latency_update",  64'(bus.update),      64'd1);
    checkOutput("latency_digit0",  64'(bus.digits[3:0]), 64'h1);
    checkOutput("latency_valid0",  64'(bus.valid[0]),    64'd1);
    @(negedge clk);

    $display("[TB] random dwells");
    for (int n = 0; n < 60; n++) begin
      dpb = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: seg = {dpb, seg_tab[$urandom_range(0, 15)]};
        7:                   seg = {dpb, 7'h7F};
        default:             seg = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) < 8) an = ~(ND'(1) << $urandom_range(0, ND - 1));
      else                          an = ND'($urandom);
      if (seg == last_seg && an == last_an) seg = seg ^ 8'h01;
      if ($urandom_range(0, 2) == 0) len = $urandom_range(1, S - 1);
      else                           len = $urandom_range(S + 2, S + 12);
      applyStimulus(seg, an, len);
    end

    if (last_an == '1) applyStimulus(8'hFF, 4'b0000, 10);
    else               applyStimulus(8'hFF, '1, 10);
    checkOutput("pending_commits", 64'(exp_q.size()), 64'd0);
    checkState("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
